gcm_stream_engine: RTL and testbench

Parametrised successor to the fixed 16-bit GCM datapath. It sequences a single-port memory, pulls counter-mode keystream words from an external block cipher over a request/valid handshake, and encrypts or decrypts N blocks. It computes GHASH with an internal bit-serial GF(2^W) multiplier and writes the tag after the last block. The hard-wired clk/4 divided clock is replaced by a parametrised clock enable, so all logic runs on `clk`.

---
 rtl/gcm_stream_engine.sv | 191 +++++++++++++++++++
 tb/tb_gcm_stream_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcm_stream_engine.sv
// Counter-mode encrypt/decrypt over a single-port memory with GHASH tag generation.
// All state advances on a clock-enable tick every CLK_DIV cycles of clk.
module gcm_stream_engine #(
  parameter int              W        = 16,
  parameter int              ADDR_W   = 6,
  parameter int              CLK_DIV  = 4,
  parameter logic [W-1:0]    POLY     = 16'h002D,
  parameter int              SRC_BASE = 0,
  parameter int              DST_BASE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] n_blk,
  input  logic [W-1:0]      h,
  output logic              ks_req,
  output logic [ADDR_W:0]   ks_ctr,
  input  logic              ks_valid,
  input  logic [W-1:0]      ks_data,
  output logic              en_memory,
  output logic              en_r,
  output logic              en_w,
  output logic [ADDR_W-1:0] addr,
  output logic [W-1:0]      d,
  input  logic [W-1:0]      q,
  output logic [W-1:0]      mac,
  output logic              busy,
  output logic              done,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_KS0 = 4'd1, S_RD  = 4'd2, S_KS   = 4'd3,
    S_WR   = 4'd4, S_MUL = 4'd5, S_TAG = 4'd6, S_DONE = 4'd7
  } state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int JW = (W > 1) ? $clog2(W) : 1;
  localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);

  state_t            cur, nxt;
  logic [CW-1:0]     div_cnt;
  logic              tick;
  logic              mode_r;
  logic [ADDR_W-1:0] n_r, i_r;
  logic [W-1:0]      h_r, ek0, y, r, c, z, v, mac_r, q_hold;
  logic              q_held;
  logic [JW-1:0]     j;
  logic [W-1:0]      q_cur, z_next, v_next;
  logic              last_step, last_blk;

  assign tick = (div_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CW'(1);
  end

  // Memory q is held across a keystream stall so a later read cannot disturb it.
  assign q_cur     = q_held ? q_hold : q;
  assign z_next    = h_r[j] ? (z ^ v) : z;
  assign v_next    = {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
  assign last_step = (j == JW'(W - 1));
  assign last_blk  = ((i_r + ADDR_W'(1)) == n_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cur <= S_IDLE;
    else if (tick) cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE: if (start) nxt = S_KS0;
      S_KS0:  if (ks_valid) nxt = (n_r == '0) ? S_TAG : S_RD;
      S_RD:   nxt = S_KS;
      S_KS:   if (ks_valid) nxt = S_WR;
      S_WR:   nxt = S_MUL;
      S_MUL:  if (last_step) nxt = last_blk ? S_TAG : S_RD;
      S_TAG:  nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ks_req    = 1'b0;
    ks_ctr    = '0;
    en_memory = 1'b0;
    en_r      = 1'b0;
    en_w      = 1'b0;
    addr      = '0;
    d         = '0;
    done      = 1'b0;
    busy      = (cur != S_IDLE);
    unique case (cur)
      S_KS0: ks_req = 1'b1;
      S_RD: begin
        en_memory = 1'b1;
        en_r      = 1'b1;
        addr      = SRC_A + i_r;
      end
      S_KS: begin
        ks_req = 1'b1;
        ks_ctr = {1'b0, i_r} + (ADDR_W+1)'(1);
      end
      S_WR: begin
        en_memory = 1'b1;
        en_w      = 1'b1;
        addr      = DST_A + i_r;
        d         = r;
      end
      S_TAG: begin
        en_memory = 1'b1;
        en_w      = 1'b1;
        addr      = DST_A + n_r;
        d         = y ^ ek0;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign state = cur;
  assign mac   = mac_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= 1'b0;
      n_r    <= '0;
      i_r    <= '0;
      h_r    <= '0;
      ek0    <= '0;
      y      <= '0;
      r      <= '0;
      c      <= '0;
      z      <= '0;
      v      <= '0;
      j      <= '0;
      mac_r  <= '0;
      q_hold <= '0;
      q_held <= 1'b0;
    end else if (tick) begin
      unique case (cur)
        S_IDLE: if (start) begin
          mode_r <= mode;
          n_r    <= n_blk;
          h_r    <= h;
          i_r    <= '0;
          mac_r  <= '0;
        end
        S_KS0: if (ks_valid) begin
          ek0 <= ks_data;
          y   <= '0;
        end
        S_RD: q_held <= 1'b0;
        S_KS: begin
          if (ks_valid) begin
            r      <= q_cur ^ ks_data;
            c      <= mode_r ? q_cur : (q_cur ^ ks_data);
            q_held <= 1'b0;
          end else begin
            q_hold <= q_cur;
            q_held <= 1'b1;
          end
        end
        // GHASH always absorbs the ciphertext, which is q itself when decrypting.
        S_WR: begin
          v <= y ^ c;
          z <= '0;
          j <= '0;
        end
        S_MUL: begin
          z <= z_next;
          v <= v_next;
          j <= j + JW'(1);
          if (last_step) begin
            y   <= z_next;
            i_r <= i_r + ADDR_W'(1);
          end
        end
        S_TAG: mac_r <= y ^ ek0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcm_stream_engine.sv
// Directed bench for gcm_stream_engine: memory/keystream models and a write scoreboard
// fed by an independent carry-less-multiply GHASH model.
module tb_gcm_stream_engine;
  localparam int W       = 16;
  localparam int ADDR_W  = 6;
  localparam int CLK_DIV = 4;
  localparam int DST     = 32;
  localparam logic [W-1:0] POLY = 16'h002D;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] n_blk;
  logic [W-1:0]      h;
  logic              ks_req;
  logic [ADDR_W:0]   ks_ctr;
  logic              ks_valid;
  logic [W-1:0]      ks_data;
  logic              en_memory, en_r, en_w;
  logic [ADDR_W-1:0] addr;
  logic [W-1:0]      d;
  logic [W-1:0]      q = '0;
  logic [W-1:0]      mac;
  logic              busy, done;
  logic [3:0]        state;

  logic [W-1:0] src_mem [0:63];
  logic [W-1:0] ks_tab  [0:127];
  logic         stall;

  logic [W-1:0]      exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  int checks = 0;
  int errors = 0;
  int busy_cnt, done_cnt;
  logic prev_w, saw_rd;

  always #5 clk = ~clk;

  gcm_stream_engine #(
    .W(W), .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV), .POLY(POLY),
    .SRC_BASE(0), .DST_BASE(DST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .n_blk(n_blk), .h(h),
    .ks_req(ks_req), .ks_ctr(ks_ctr), .ks_valid(ks_valid), .ks_data(ks_data),
    .en_memory(en_memory), .en_r(en_r), .en_w(en_w), .addr(addr), .d(d), .q(q),
    .mac(mac), .busy(busy), .done(done), .state(state)
  );

  assign ks_data  = ks_tab[ks_ctr];
  assign ks_valid = ks_req & ~stall;

  always @(posedge clk) begin
    if (en_memory && en_r) q <= src_mem[addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = '0;
    for (int k = 0; k < W; k++)
      if (b[k]) p = p ^ ({{W{1'b0}}, a} << k);
    for (int k = 2*W-2; k >= W; k--)
      if (p[k]) begin
        p[k] = 1'b0;
        p = p ^ ({{W{1'b0}}, POLY} << (k - W));
      end
    return p[W-1:0];
  endfunction

  task automatic build_expect(input logic md, input int n, input logic [W-1:0] hv,
                              output logic [W-1:0] tag);
    logic [W-1:0] yv, p, rv, cv;
    yv = '0;
    for (int i = 0; i < n; i++) begin
      p  = src_mem[i];
      rv = p ^ ks_tab[i+1];
      cv = md ? p : rv;
      exp_addr_q.push_back(ADDR_W'(DST + i));
      exp_q.push_back(rv);
      yv = gf_mul(yv ^ cv, hv);
    end
    tag = yv ^ ks_tab[0];
    exp_addr_q.push_back(ADDR_W'(DST + n));
    exp_q.push_back(tag);
  endtask

  // One clk cycle; DUT outputs are observed on the falling edge.
  task automatic step();
    logic [ADDR_W-1:0] ea;
    logic [W-1:0]      ed;
    @(negedge clk);
    if (en_memory && en_r) saw_rd = 1'b1;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (en_memory && en_w && !prev_w) begin
      checks++;
      assert (exp_addr_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr %0d data %0h, expected no write", addr, d);
      end
      if (exp_addr_q.size() != 0) begin
        ea = exp_addr_q.pop_front();
        ed = exp_q.pop_front();
        chk("wr_addr", 32'(addr), 32'(ea));
        chk("wr_data", 32'(d), 32'(ed));
      end
    end
    prev_w = en_memory && en_w;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_strobes"}, {28'd0, ks_req, en_memory, en_r, en_w}, 0);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_d"}, 32'(d), 0);
    chk({tag, "_ks_ctr"}, 32'(ks_ctr), 0);
    chk({tag, "_mac"}, 32'(mac), 0);
  endtask

  task automatic run_op(input string tag, input logic md, input int n, input logic [W-1:0] hv,
                        input logic stall_en, input logic pulse_en, output logic [W-1:0] tag_exp);
    int  ticks;
    logic finished, stalled, hold_ok;
    build_expect(md, n, hv, tag_exp);
    mode = md; n_blk = ADDR_W'(n); h = hv;
    busy_cnt = 0; done_cnt = 0; saw_rd = 1'b0;
    finished = 1'b0; stalled = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 4*CLK_DIV && !busy; k++) step();
    chk({tag, "_busy_rise"}, 32'(busy), 1);
    start = 1'b0;
    for (int k = 0; k < 6000 && !finished; k++) begin
      start = pulse_en && busy_cnt >= 40 && busy_cnt < 48;
      if (stall_en && !stalled && state == 4'd3) begin
        stalled = 1'b1;
        stall   = 1'b1;
        hold_ok = 1'b1;
        for (int s = 0; s < 5*CLK_DIV; s++) begin
          step();
          if (!(ks_req && ks_ctr == 1 && !en_w)) hold_ok = 1'b0;
        end
        stall = 1'b0;
        chk({tag, "_stall_hold"}, 32'(hold_ok), 1);
      end
      step();
      if (!busy) finished = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_finished"}, 32'(finished), 1);
    ticks = 3 + n*(3+W) + (stall_en ? 5 : 0);
    chk({tag, "_latency"}, 32'(busy_cnt), 32'(ticks*CLK_DIV));
    chk({tag, "_done_len"}, 32'(done_cnt), CLK_DIV);
    chk({tag, "_mac"}, 32'(mac), 32'(tag_exp));
    chk({tag, "_pending"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic [W-1:0] t;
    int wr_seen;
    logic hit;
    logic [3:0] prev_state;

    rst = 1'b1; start = 1'b0; mode = 1'b0; n_blk = '0; h = '0; stall = 1'b0; prev_w = 1'b0;
    for (int i = 0; i < 64; i++) src_mem[i] = '0;
    for (int i = 0; i < 128; i++) ks_tab[i] = '0;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Basic encrypt
    ks_tab[0] = 16'h0000; ks_tab[1] = 16'h1234; src_mem[0] = 16'h0001;
    run_op("enc1", 1'b0, 1, 16'h0001, 1'b0, 1'b0, t);
    chk("enc1_mac_const", 32'(mac), 32'h1235);

    // Reduction through POLY
    ks_tab[0] = 16'h0F0F; ks_tab[1] = 16'h0000; src_mem[0] = 16'h8000;
    run_op("reduce", 1'b0, 1, 16'h0002, 1'b0, 1'b0, t);
    chk("reduce_mac_const", 32'(mac), 32'h0F22);

    // Decrypt hashes ciphertext
    ks_tab[0] = 16'h0000; ks_tab[1] = 16'h1234; src_mem[0] = 16'h1235;
    run_op("dec1", 1'b1, 1, 16'h0001, 1'b0, 1'b0, t);
    chk("dec1_mac_const", 32'(mac), 32'h1235);

    // Zero blocks: tag only
    ks_tab[0] = 16'hBEEF;
    run_op("zero", 1'b0, 0, 16'h1357, 1'b0, 1'b0, t);
    chk("zero_no_read", 32'(saw_rd), 0);
    chk("zero_mac_const", 32'(mac), 32'hBEEF);

    // Keystream stall plus start pulsed while busy
    ks_tab[0] = 16'h0000; ks_tab[1] = 16'h1234; src_mem[0] = 16'h0001;
    run_op("stall", 1'b0, 1, 16'h0001, 1'b1, 1'b1, t);
    chk("stall_mac_const", 32'(mac), 32'h1235);

    // Random multi-block encrypt and decrypt
    for (int i = 0; i < 4; i++) src_mem[i] = W'($urandom_range(0, 16'hFFFF));
    for (int i = 0; i < 5; i++) ks_tab[i] = W'($urandom_range(0, 16'hFFFF));
    run_op("rand_enc", 1'b0, 3, W'($urandom_range(1, 16'hFFFF)), 1'b0, 1'b0, t);
    run_op("rand_dec", 1'b1, 2, W'($urandom_range(1, 16'hFFFF)), 1'b0, 1'b0, t);

    // Abort with reset during the multiply of block 1 of 3
    build_expect(1'b0, 3, 16'hA5C3, t);
    mode = 1'b0; n_blk = 3; h = 16'hA5C3; start = 1'b1;
    wr_seen = 0; hit = 1'b0; prev_state = state;
    for (int k = 0; k < 2000 && !hit; k++) begin
      step();
      if (busy) start = 1'b0;
      if (state == 4'd4 && prev_state != 4'd4) wr_seen++;
      if (wr_seen == 2 && state == 4'd5) hit = 1'b1;
      prev_state = state;
    end
    chk("abort_reached_mul", 32'(hit), 1);
    start = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < 3*CLK_DIV; k++) step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 3; i++) src_mem[i] = W'($urandom_range(0, 16'hFFFF));
    for (int i = 0; i < 4; i++) ks_tab[i] = W'($urandom_range(0, 16'hFFFF));
    run_op("fresh", 1'b0, 3, 16'hA5C3, 1'b0, 1'b0, t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
